// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access controller: FSM states, requester ids
// and the default main-memory depth in 32-bit words.
package mem_ctrl_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 8192;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the requesters/main memory and the access controller.
// slave: the controller's view; master: the requesters' and memory's view.
interface mem_access_ctrl_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;

  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    input  mem_data_out,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output mem_address, mem_read_enable, mem_write_enable, mem_data_in
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    output mem_data_out,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  mem_address, mem_read_enable, mem_write_enable, mem_data_in
  );

endinterface

// File: rtl/mem_access_ctrl_arbiter.sv
// mem_arbiter: two-way round-robin grant between instruction fetch and data.
// On a tie the port that did not win last time is chosen; last-grant starts
// at IF so the very first tie goes to data.
module mem_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_if_valid,
  input  logic  i_d_valid,
  input  logic  i_accept,
  output port_e o_grant
);

  port_e r_last;

  // Pick the winner: lone requester wins, a tie goes away from the last winner
  always_comb begin
    o_grant = PORT_IF;
    if (i_if_valid && i_d_valid) begin
      o_grant = (r_last == PORT_IF) ? PORT_D : PORT_IF;
    end else if (i_d_valid) begin
      o_grant = PORT_D;
    end
  end

  // Remember the winner of each accepted request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= PORT_IF;
    end else if (i_accept) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: shares one single-port main memory between an instruction
// fetch port and a data port. One request in flight: IDLE -> ACCESS -> RESP.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (misaligned / out-of-range
// accesses skip the memory and answer with data 0 and d_rsp_err=1).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  state_e      r_state;
  state_e      w_state_next;
  port_e       r_port;
  port_e       w_grant;
  logic        r_we;
  logic [29:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_data;
  logic        w_any_valid;
  logic        w_accept;
  logic        w_bad;
  logic        w_rsp_ready;
  logic [29:0] w_req_word;

  assign w_any_valid = bus.if_req_valid || bus.d_req_valid;
  assign w_accept    = rst_n && (r_state == ST_IDLE) && w_any_valid;
  assign w_req_word  = (w_grant == PORT_D) ? bus.d_req_addr[31:2] : bus.if_req_addr[31:2];
  assign w_rsp_ready = (r_port == PORT_IF) ? bus.if_rsp_ready : bus.d_rsp_ready;

  mem_arbiter u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_valid (bus.if_req_valid),
    .i_d_valid  (bus.d_req_valid),
    .i_accept   (w_accept),
    .o_grant    (w_grant)
  );

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [29:0] LP_DEPTH = 30'(DEPTH_WORDS);
  logic r_mis;
  logic r_err;

  // Capture misalignment of the accepted request; latch its error on the ACCESS edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mis <= (w_grant == PORT_D) ? (bus.d_req_addr[1:0] != 2'b00)
                                     : (bus.if_req_addr[1:0] != 2'b00);
      end
      if (r_state == ST_ACCESS) begin
        r_err <= w_bad;
      end
    end
  end

  assign w_bad         = r_mis || (r_word >= LP_DEPTH);
  assign bus.d_rsp_err = r_err;
`else
  assign w_bad         = 1'b0;
  assign bus.d_rsp_err = 1'b0;
`endif

  // State register and capture of the request accepted in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_port  <= PORT_IF;
      r_we    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_port  <= w_grant;
        r_we    <= (w_grant == PORT_D) && bus.d_req_we;
        r_word  <= w_req_word;
        r_wdata <= bus.d_req_wdata;
      end
    end
  end

  // Response data: memory read data on the ACCESS edge, zero for stores and errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_rsp_data <= (r_we || w_bad) ? 32'd0 : bus.mem_data_out;
    end
  end

  assign bus.if_rsp_data = r_rsp_data;
  assign bus.d_rsp_rdata = r_rsp_data;

  // Next state, handshakes and memory strobes (strobes also gated by rst_n)
  always_comb begin
    w_state_next         = r_state;
    bus.if_req_ready     = 1'b0;
    bus.d_req_ready      = 1'b0;
    bus.if_rsp_valid     = 1'b0;
    bus.d_rsp_valid      = 1'b0;
    bus.mem_address      = '0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_data_in      = '0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n && w_any_valid) begin
          bus.if_req_ready = (w_grant == PORT_IF);
          bus.d_req_ready  = (w_grant == PORT_D);
          w_state_next     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.mem_address = {2'b00, r_word};
        if (rst_n && !w_bad) begin
          bus.mem_read_enable  = !r_we;
          bus.mem_write_enable = r_we;
          bus.mem_data_in      = r_we ? r_wdata : 32'd0;
        end
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.if_rsp_valid = (r_port == PORT_IF);
        bus.d_rsp_valid  = (r_port == PORT_D);
        if (w_rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: main memory modelled as an array with
// combinational read, a separate reference memory predicting contents,
// and a round-robin rule model predicting grant order.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_ctrl_if ifc ();

  mem_access_ctrl #(.DEPTH_WORDS(DEPTH_WORDS_DEFAULT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_ram  [0:8191];
  logic [31:0] ref_mem [0:8191];
  int          n_checks = 0;
  int          n_fail   = 0;
  port_e       m_last;

  assign ifc.mem_data_out = tb_ram[ifc.mem_address[12:0]];

  always @(posedge clk) begin
    if (ifc.mem_write_enable) tb_ram[ifc.mem_address[12:0]] <= ifc.mem_data_in;
  end

  function automatic bit model_err(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH_WORDS_DEFAULT));
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input port_e p, input req_t r);
    if (p == PORT_IF) begin
      ifc.if_req_valid = 1'b1;
      ifc.if_req_addr  = r.addr;
    end else begin
      ifc.d_req_valid = 1'b1;
      ifc.d_req_we    = r.we;
      ifc.d_req_addr  = r.addr;
      ifc.d_req_wdata = r.wdata;
    end
  endtask

  // Serve the request the model says is granted now; fixed-latency checks
  task automatic serve_one(input port_e p, input req_t r, input int delay);
    bit          e;
    logic [31:0] exp_data;
    logic [31:0] got;
    logic        got_v;
    e        = model_err(r.addr);
    exp_data = (r.we || e) ? 32'd0 : ref_mem[r.addr[14:2]];
    #1;
    n_checks++;
    if (ifc.if_req_ready !== (p == PORT_IF) || ifc.d_req_ready !== (p == PORT_D)) begin
      n_fail++;
      $display("FAIL grant: if_rdy=%b d_rdy=%b, required port %s", ifc.if_req_ready, ifc.d_req_ready, p.name());
    end
    @(posedge clk); #1;
    if (p == PORT_IF) ifc.if_req_valid = 1'b0; else ifc.d_req_valid = 1'b0;
    n_checks++;
    if (ifc.mem_address !== {2'b00, r.addr[31:2]}) begin
      n_fail++;
      $display("FAIL mem_address: got %h required %h", ifc.mem_address, {2'b00, r.addr[31:2]});
    end
    n_checks++;
    if (ifc.mem_read_enable !== (!r.we && !e) || ifc.mem_write_enable !== (r.we && !e)) begin
      n_fail++;
      $display("FAIL strobes: re=%b we=%b required re=%b we=%b", ifc.mem_read_enable, ifc.mem_write_enable, !r.we && !e, r.we && !e);
    end
    if (r.we && !e) begin
      n_checks++;
      if (ifc.mem_data_in !== r.wdata) begin
        n_fail++;
        $display("FAIL mem_data_in: got %h required %h", ifc.mem_data_in, r.wdata);
      end
      ref_mem[r.addr[14:2]] = r.wdata;
    end
    @(posedge clk); #1;
    for (int i = 0; i <= delay; i++) begin
      got   = (p == PORT_IF) ? ifc.if_rsp_data : ifc.d_rsp_rdata;
      got_v = (p == PORT_IF) ? ifc.if_rsp_valid : ifc.d_rsp_valid;
      n_checks++;
      if (got_v !== 1'b1 || got !== exp_data) begin
        n_fail++;
        $display("FAIL response[%0d]: valid=%b data=%h required valid=1 data=%h", i, got_v, got, exp_data);
      end
      n_checks++;
      if (ifc.if_req_ready !== 1'b0 || ifc.d_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL no_new_grant: if_rdy=%b d_rdy=%b required 0 0", ifc.if_req_ready, ifc.d_req_ready);
      end
      if (p == PORT_D) begin
        n_checks++;
        if (ifc.d_rsp_err !== e) begin
          n_fail++;
          $display("FAIL d_rsp_err: got %b required %b", ifc.d_rsp_err, e);
        end
      end
      if (i == delay) begin
        if (p == PORT_IF) ifc.if_rsp_ready = 1'b1; else ifc.d_rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    ifc.if_rsp_ready = 1'b0;
    ifc.d_rsp_ready  = 1'b0;
    n_checks++;
    if (ifc.if_rsp_valid !== 1'b0 || ifc.d_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_release: if_v=%b d_v=%b required 0 0", ifc.if_rsp_valid, ifc.d_rsp_valid);
    end
    m_last = p;
    $display("txn port=%s we=%0b addr=%h wdata=%h rsp=%h err=%0b stall=%0d",
             p.name(), r.we, r.addr, r.wdata, exp_data, e, delay);
  endtask

  task automatic run_single(input port_e p, input req_t r, input int delay);
    set_req(p, r);
    serve_one(p, r, delay);
  endtask

  // Both ports request together; the tie goes away from the last winner
  task automatic run_pair(input req_t ri, input req_t rd, input int delay);
    port_e first;
    set_req(PORT_IF, ri);
    set_req(PORT_D, rd);
    first = (m_last == PORT_IF) ? PORT_D : PORT_IF;
    if (first == PORT_D) begin
      serve_one(PORT_D, rd, delay);
      serve_one(PORT_IF, ri, delay);
    end else begin
      serve_one(PORT_IF, ri, delay);
      serve_one(PORT_D, rd, delay);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_last = PORT_IF;
  endtask

  task automatic test_reset();
    ifc.if_req_valid = 1'b1;
    ifc.d_req_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ifc.if_req_ready !== 1'b0 || ifc.d_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: if=%b d=%b required 0 0", ifc.if_req_ready, ifc.d_req_ready);
    end
    n_checks++;
    if (ifc.if_rsp_valid !== 1'b0 || ifc.d_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp_valid: if=%b d=%b required 0 0", ifc.if_rsp_valid, ifc.d_rsp_valid);
    end
    n_checks++;
    if (ifc.mem_read_enable !== 1'b0 || ifc.mem_write_enable !== 1'b0 || ifc.mem_data_in !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: re=%b we=%b din=%h required 0 0 0", ifc.mem_read_enable, ifc.mem_write_enable, ifc.mem_data_in);
    end
    n_checks++;
    if (ifc.d_rsp_rdata !== 32'd0 || ifc.if_rsp_data !== 32'd0 || ifc.d_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: d=%h if=%h err=%b required 0 0 0", ifc.d_rsp_rdata, ifc.if_rsp_data, ifc.d_rsp_err);
    end
    ifc.if_req_valid = 1'b0;
    ifc.d_req_valid  = 1'b0;
    rst_n  = 1'b1;
    m_last = PORT_IF;
  endtask

  task automatic test_store_load();
    run_single(PORT_D, '{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF}, 0);
    n_checks++;
    if (tb_ram[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_commit: ram[4]=%h required deadbeef", tb_ram[4]);
    end
    run_single(PORT_D, '{we: 1'b0, addr: 32'h10, wdata: 32'h0}, 0);
  endtask

  task automatic test_arbitration();
    req_t ri;
    req_t rd;
    ri = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    rd = '{we: 1'b0, addr: 32'h10, wdata: 32'h0};
    pulse_reset();
    run_pair(ri, rd, 0);
    run_pair(ri, rd, 1);
  endtask

  task automatic test_backpressure();
    pulse_reset();
    run_pair('{we: 1'b0, addr: 32'h40, wdata: 32'h0}, '{we: 1'b0, addr: 32'h10, wdata: 32'h0}, 5);
  endtask

  task automatic test_reset_mid();
    req_t r;
    r = '{we: 1'b1, addr: 32'h20, wdata: 32'h12345678};
    set_req(PORT_D, r);
    @(posedge clk); #1;
    ifc.d_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifc.mem_write_enable !== 1'b0 || ifc.mem_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_strobe: we=%b re=%b required 0 0", ifc.mem_write_enable, ifc.mem_read_enable);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_last = PORT_IF;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ifc.if_rsp_valid !== 1'b0 || ifc.d_rsp_valid !== 1'b0 || ifc.d_rsp_rdata !== 32'd0 || ifc.d_rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_norsp: if_v=%b d_v=%b data=%h err=%b required 0 0 0 0",
                 ifc.if_rsp_valid, ifc.d_rsp_valid, ifc.d_rsp_rdata, ifc.d_rsp_err);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (tb_ram[8] !== ref_mem[8]) begin
      n_fail++;
      $display("FAIL reset_mid_mem: ram[8]=%h required %h", tb_ram[8], ref_mem[8]);
    end
    run_single(PORT_D, '{we: 1'b0, addr: 32'h20, wdata: 32'h0}, 0);
  endtask

  task automatic test_bounds();
    run_single(PORT_D, '{we: 1'b0, addr: 32'h8000, wdata: 32'h0}, 0);
    run_single(PORT_D, '{we: 1'b0, addr: 32'h2, wdata: 32'h0}, 0);
    run_single(PORT_D, '{we: 1'b1, addr: 32'h9, wdata: 32'hA5A5A5A5}, 0);
    run_single(PORT_IF, '{we: 1'b0, addr: 32'h6, wdata: 32'h0}, 1);
    run_single(PORT_D, '{we: 1'b0, addr: 32'h8, wdata: 32'h0}, 0);
  endtask

  function automatic req_t rand_req(input bit is_d);
    req_t r;
    r.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
    r.addr  = {17'd0, 13'($urandom_range(0, 8191)), 2'b00};
    r.wdata = $urandom;
    if ($urandom_range(0, 7) == 0) r.addr[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) r.addr[16:15] = 2'($urandom_range(1, 3));
    return r;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       run_single(PORT_IF, rand_req(1'b0), $urandom_range(0, 3));
        1:       run_single(PORT_D, rand_req(1'b1), $urandom_range(0, 3));
        default: run_pair(rand_req(1'b0), rand_req(1'b1), $urandom_range(0, 3));
      endcase
    end
  endtask

  initial begin
    ifc.if_req_valid = 1'b0;
    ifc.if_req_addr  = '0;
    ifc.if_rsp_ready = 1'b0;
    ifc.d_req_valid  = 1'b0;
    ifc.d_req_we     = 1'b0;
    ifc.d_req_addr   = '0;
    ifc.d_req_wdata  = '0;
    ifc.d_rsp_ready  = 1'b0;
    m_last           = PORT_IF;
    for (int i = 0; i < 8192; i++) begin
      tb_ram[i]  = $urandom;
      ref_mem[i] = tb_ram[i];
    end
    test_reset();
    test_store_load();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clock/reset: one clock; reset is synchronous and active-low.
REQ-002 Parameter DEPTH_WORDS, 8192, number of 32-bit words in main memory.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 if_req_valid / if_req_ready  in / out  1 / 1  instruction-fetch read request handshake.
REQ-006 if_req_addr  in  32  byte address of the fetch.
REQ-007 if_rsp_valid / if_rsp_ready  out / in  1 / 1  fetch response handshake.
REQ-008 if_rsp_data  out  32  fetched word.
REQ-009 d_req_valid / d_req_ready  in / out  1 / 1  data request handshake.
REQ-010 d_req_we  in  1  1 = store, 0 = load.
REQ-011 d_req_addr / d_req_wdata  in  32 / 32  byte address and store data.
REQ-012 d_rsp_valid / d_rsp_ready  out / in  1 / 1  data response handshake.
REQ-013 d_rsp_rdata  out  32  load data; 0 for stores.
REQ-014 d_rsp_err  out  1  access error flag.
REQ-015 mem_address  out  32  word index into main memory.
REQ-016 mem_read_enable / mem_write_enable  out  1 / 1  main-memory strobes.
REQ-017 mem_data_in / mem_data_out  out / in  32 / 32  write data to memory and combinational read data from memory.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 if_req_ready and d_req_ready are asserted only in IDLE, and only for the port granted that cycle.
REQ-020 Arbitration on a tie goes to the port not granted last; the last-grant register resets to IF, so the first tie goes to data; a single valid requester is always granted.
REQ-021 A handshake in IDLE at edge N captures the address, we, wdata and port, and moves the FSM to ACCESS.
REQ-022 In ACCESS (cycle N+1):
  - mem_address = addr[31:2].
  - Load/fetch: mem_read_enable=1 and mem_write_enable=0; mem_data_out is registered into the response data at edge N+1.
  - Store: mem_write_enable=1, mem_read_enable=0 and mem_data_in=wdata; the write commits at edge N+1.
REQ-023 Outside ACCESS, mem_read_enable, mem_write_enable and mem_data_in are all 0.
REQ-024 In RESP (from N+2), the granted port's rsp_valid is held high, with data stable, until its rsp_ready is sampled high; the FSM then returns to IDLE.
REQ-025 Minimum occupancy is 3 cycles per request, and only one request is in flight at a time.
REQ-026 Strobes are gated by rst_n: rst_n low during ACCESS suppresses the write.
REQ-027 The non-granted requester's valid may stay high indefinitely and is served after the current response completes.

Reset
REQ-028 On reset:
  - FSM goes to IDLE and last-grant to IF.
  - All rsp_valid, req_ready, mem strobes, rsp data and d_rsp_err are 0.
REQ-029 Reset mid-operation discards the in-flight request without a response.

Configuration
REQ-030 With MEM_BOUNDS_CHECK_EN defined, a request with addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS still passes through ACCESS, but both strobes stay 0; the response returns data 0 with d_rsp_err=1, and an errored fetch returns data 0.
REQ-031 Without MEM_BOUNDS_CHECK_EN:
  - d_rsp_err is tied to 0.
  - addr[1:0] is ignored.
  - addr[31:2] is passed through unchecked.

Structure
REQ-032 Package mem_ctrl_pkg holds the FSM state enum, the port-id enum (PORT_IF, PORT_D) and DEPTH_WORDS_DEFAULT.
REQ-033 Sub-module mem_arbiter is the 2-way round-robin grant with last-grant state.

Verification
REQ-034 Store to 0x10 with data 0xDEADBEEF, then load from 0x10: mem_write_enable is pulsed with mem_address=4, and the load returns 0xDEADBEEF at cycle N+2.
REQ-035 Both valid from reset, fetch at 0x0 and load at 0x10: data is granted first, IF second, and on a repeated tie the grant alternates.
REQ-036 d_rsp_ready held low for 5 cycles: d_rsp_valid and its data are held stable, and no new grant is made.
REQ-037 rst_n pulsed low during a store's ACCESS cycle: no write occurs, the memory word is unchanged, and no response is issued.
REQ-038 With MEM_BOUNDS_CHECK_EN, a load at 0x8000 or 0x2: d_rsp_err=1 and data 0, with no memory strobe; without the macro, 0x2 reads word 0.
